// File: rtl/arb_pkg.sv
// Shared arbitration types and helpers for the round-robin arbiter family.
package arb_pkg;
    localparam int N   = 8;
    localparam int IDW = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Bits at or above the rotating pointer form the first-pass search window.
    function automatic logic [N-1:0] rr_mask(input logic [IDW-1:0] ptr);
        logic [N-1:0] m;
        for (int i = 0; i < N; i++) begin
            m[i] = (i >= int'(ptr));
        end
        return m;
    endfunction
endpackage

// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_arbiter_8_if;
    logic [arb_pkg::N-1:0]   req;
    logic [arb_pkg::N-1:0]   gnt;
    logic [arb_pkg::IDW-1:0] gnt_id;
    logic                    gnt_valid;
    logic                    timeout;

    modport master (output req, input gnt, input gnt_id, input gnt_valid, input timeout);
    modport slave  (input req, output gnt, output gnt_id, output gnt_valid, output timeout);
endinterface

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: lowest request at/above ptr, else lowest overall.
module rr_pick
    import arb_pkg::*;
(
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [IDW-1:0] pick_id,
    output logic [N-1:0]   pick_oh,
    output logic           pick_any
);
    logic [N-1:0] masked;
    logic [N-1:0] pool;

    always_comb begin
        masked  = req & rr_mask(ptr);
        pool    = (masked != '0) ? masked : req;
        pick_id = '0;
        // Descending scan so the lowest set bit is the last assignment.
        for (int i = N - 1; i >= 0; i--) begin
            if (pool[i]) pick_id = IDW'(i);
        end
        pick_any         = |req;
        pick_oh          = '0;
        pick_oh[pick_id] = pick_any;
    end
endmodule

// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with registered grant and optional hold timeout.
module rr_arbiter_8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNTW     = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    rr_arbiter_8_if.slave  bus
);
    localparam logic [CNTW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNTW'(MAX_HOLD - 1);

    state_t          state, state_nxt;
    logic [IDW-1:0]  ptr, ptr_nxt;
    logic [CNTW-1:0] hold_cnt, hold_nxt;
    logic [N-1:0]    gnt_p0, gnt_nxt;
    logic [IDW-1:0]  gnt_id_p0, gnt_id_nxt;
    logic            vld_p0, vld_nxt;
    logic            timeout_p0, timeout_nxt;

    logic [IDW-1:0]  pick_id;
    logic [N-1:0]    pick_oh;
    logic            pick_any;
    logic            owner_req;
    logic            hold_hit;

    rr_pick u_pick (
        .req      (bus.req),
        .ptr      (ptr),
        .pick_id  (pick_id),
        .pick_oh  (pick_oh),
        .pick_any (pick_any)
    );

    assign owner_req = bus.req[gnt_id_p0];
    assign hold_hit  = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        hold_nxt    = hold_cnt;
        gnt_nxt     = gnt_p0;
        gnt_id_nxt  = gnt_id_p0;
        vld_nxt     = vld_p0;
        timeout_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    gnt_nxt    = pick_oh;
                    gnt_id_nxt = pick_id;
                    vld_nxt    = 1'b1;
                    hold_nxt   = '0;
                    state_nxt  = GRANT;
                end
            end
            GRANT: begin
                if (!owner_req || hold_hit) begin
                    // Advancing past the owner gives it lowest priority next round.
                    gnt_nxt     = '0;
                    vld_nxt     = 1'b0;
                    ptr_nxt     = gnt_id_p0 + IDW'(1);
                    hold_nxt    = '0;
                    timeout_nxt = owner_req;
                    state_nxt   = IDLE;
                end else if (hold_cnt != '1) begin
                    hold_nxt = hold_cnt + CNTW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            hold_cnt   <= '0;
            gnt_p0     <= '0;
            gnt_id_p0  <= '0;
            vld_p0     <= 1'b0;
            timeout_p0 <= 1'b0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            hold_cnt   <= hold_nxt;
            gnt_p0     <= gnt_nxt;
            gnt_id_p0  <= gnt_id_nxt;
            vld_p0     <= vld_nxt;
            timeout_p0 <= timeout_nxt;
        end
    end

    assign bus.gnt       = gnt_p0;
    assign bus.gnt_id    = gnt_id_p0;
    assign bus.gnt_valid = vld_p0;
    assign bus.timeout   = timeout_p0;
endmodule

// File: doc/rr_arbiter_8.md
Name: rr_arbiter_8

Overview:
- Round-robin arbiter sharing one resource between 8 requesters.
- Built around masked priority encoding: a request vector goes in; a registered one-hot grant, a 3-bit grant index and a valid flag come out.
- Holds a grant until the owner drops its request or a hold-timeout expires.
- Sits in front of any shared datapath that today takes a raw priority-encoded select.

Parameters:
- N, 8, number of requesters (fixed at 8 for this revision).
- IDW, 3, grant index width (log2 N).
- MAX_HOLD, 16, maximum consecutive cycles one owner may hold the grant; 0 disables the timeout.
- CNTW, 5, hold counter width; must satisfy 2^CNTW > MAX_HOLD.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  8  request vector; bit i asserted by requester i.
- gnt  out  8  one-hot grant; all zeros when no grant.
- gnt_id  out  3  binary index of current owner; valid only when gnt_valid=1.
- gnt_valid  out  1  a grant is active.
- timeout  out  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- Reset, asynchronous on rst_n=0:
  - gnt=0, gnt_id=0, gnt_valid=0, timeout=0.
  - State=IDLE, ptr=0, hold_cnt=0.
  - Reset mid-grant drops the grant immediately, without waiting for a clock.
- All outputs are registered, and gnt, gnt_id and gnt_valid are always mutually consistent.
- Arbitration (combinational, in sub-module):
  - Search starts at index ptr and goes upward with wrap-around (ptr, ptr+1, …, 7, 0, …, ptr-1).
  - The first asserted req bit wins.
  - Implementation: masked pass over req & (bits >= ptr); if empty, unmasked pass over req; lowest index wins in each pass.
- State IDLE:
  - If req != 0 at a rising edge, load gnt/gnt_id with the winner, set gnt_valid=1, hold_cnt=0, and go to GRANT.
  - Request-to-grant latency is 1 cycle.
  - If req == 0, stay in IDLE.
- State GRANT, evaluated each edge:
  - Release if req[gnt_id]=0, or if MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1.
  - On release:
    - gnt=0, gnt_valid=0.
    - ptr = gnt_id+1 mod 8, so 7 wraps to 0.
    - hold_cnt=0; go to IDLE.
    - timeout=1 for exactly that cycle only if release was forced while req[gnt_id] was still 1.
  - Otherwise hold the outputs and increment hold_cnt (saturating, never wraps).
- Dead cycle: every release is followed by at least one cycle with gnt_valid=0. A new grant is never issued in the same edge as a release.
- Non-owner req changes during GRANT are ignored; they are evaluated at the next IDLE arbitration.
- Simultaneous release and re-request by the owner: the owner has lowest priority in the next arbitration because ptr has advanced. It is re-granted only if no other request is pending.
- Single requester: may be re-granted repeatedly, with a dead cycle between grants.
- Outputs do not depend on req combinationally.

Decomposition:
- Shared package arb_pkg:
  - N, IDW constants.
  - State enum: IDLE=1'b0, GRANT=1'b1.
  - rr_mask function (bits >= ptr).
- One sub-module rr_pick: combinational masked/unmasked priority encoder.
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: pick_id[2:0], pick_oh[7:0], pick_any.
  - Reused later by other arbiters.
- Top module holds: state register, ptr, hold_cnt, output registers.

Test Plan:
- Reset: drive req=8'hFF with rst_n=0, then release rst_n. Required: gnt=0 and gnt_valid=0 while in reset; first edge after release gives gnt=8'h01, gnt_id=0.
- Rotation: hold req=8'hFF, each owner drops its req bit for one cycle after 2 cycles of grant. Required: grant order 0,1,2,…,7,0; one dead cycle between each; no index skipped or repeated.
- Wrap search: ptr=6 (after owner 5 releases), req=8'b0000_0101. Required: gnt_id=0, then gnt_id=2 on the next arbitration.
- Timeout with MAX_HOLD=4: req=8'h08 held high. Required: gnt=8'h08 for exactly 4 cycles, timeout pulses 1 cycle, 1 dead cycle, then gnt=8'h08 again.
- Async reset mid-grant: assert rst_n=0 between edges while gnt=8'h10. Required: gnt=0 and gnt_valid=0 immediately; ptr returns to 0, so req=8'h11 after reset grants index 0.
- Idle/no-glitch: req=0 for 20 cycles, then req=8'h80 for 1 cycle only. Required: gnt_valid=0 throughout the idle period; gnt=8'h80 granted for 1 cycle, released on the next edge with timeout=0.
